imagenes_lcd: RTL and testbench
===============================

Name: imagenes_lcd

Overview:
- Timing generator and test-image source for an 800x480 parallel-RGB TFT LCD panel.
- Runs from the 50 MHz system clock and derives a 25 MHz pixel clock NCLK.
- Produces horizontal sync HD, vertical sync VD, data-enable DEN, panel reset GREST and 24-bit RGB.
- Sits at the top of the display path, driving the panel pins directly.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_SYNC, 30, HD low width in pixel clocks
- H_BLANK, 216, pixel clocks from line start to first visible pixel (sync + back porch)
- H_TOTAL, 1056, pixel clocks per line (front porch = 40)
- V_ACTIVE, 480, visible lines per frame
- V_SYNC, 3, VD low width in lines
- V_BLANK, 35, lines from frame start to first visible line
- V_TOTAL, 525, lines per frame (front porch = 10)
- BAR_W, 100, width in pixels of each colour bar

Ports:
- CLK  in  1  50 MHz system clock, rising edge
- RST_n  in  1  asynchronous, active-high reset (asserted = 1 despite the port name)
- NCLK  out  1  pixel clock, CLK/2, 50 % duty
- GREST  out  1  panel global reset, active-low: 0 while RST_n asserted, 1 otherwise
- HD  out  1  horizontal sync, active-low
- VD  out  1  vertical sync, active-low
- DEN  out  1  data enable, high during visible pixels
- R  out  8  red
- G  out  8  green
- B  out  8  blue

Behaviour:
- Reset values (asynchronous, RST_n=1): NCLK=0, hcnt=0, vcnt=0, HD=1, VD=1, DEN=0, R=G=B=0, GREST=0.
- After reset release, GREST=1 and NCLK toggles on every CLK rising edge.
- A pixel step occurs on each CLK edge where NCLK goes 1->0. Outputs therefore change on NCLK falling edges and are stable at NCLK rising edges.
- hcnt counts 0..H_TOTAL-1 and wraps to 0. When hcnt wraps, vcnt increments, counting 0..V_TOTAL-1 and wrapping to 0.
- All outputs are registered and decoded from the new counter values in the same pixel step, with zero skew between HD, VD, DEN and RGB.
- HD = 0 iff hcnt < H_SYNC.
- VD = 0 iff vcnt < V_SYNC.
- DEN = 1 iff H_BLANK <= hcnt < H_BLANK+H_ACTIVE and V_BLANK <= vcnt < V_BLANK+V_ACTIVE.
- Pixel column x = hcnt - H_BLANK. The bar index is x / BAR_W, giving 0..7.
- Bar colours, left to right:
  - 0: white FF/FF/FF
  - 1: yellow FF/FF/00
  - 2: cyan 00/FF/FF
  - 3: green 00/FF/00
  - 4: magenta FF/00/FF
  - 5: red FF/00/00
  - 6: blue 00/00/FF
  - 7: black 00/00/00
- R=G=B=0 whenever DEN=0.
- The image is static: identical in every frame and every visible line.
- Frame period: 1056*525 = 554,400 NCLK = 1,108,800 CLK = 22.176 ms.
- Line period: 1056 NCLK = 42.24 us.
- Reset mid-frame: all state returns to the reset values immediately. On release, timing restarts from hcnt=0, vcnt=0, i.e. a fresh HD and VD pulse at the start of a new frame.
- No inputs other than CLK and RST_n; no handshakes.

Test Plan:
- Reset held 20 CLK at 50 MHz -> GREST=0, NCLK=0, HD=1, VD=1, DEN=0, RGB=0 throughout. After release, GREST=1 and NCLK period is 40 ns.
- HD timing on any line -> low for exactly 30 NCLK, HD falling edges exactly 1056 NCLK apart.
- VD timing -> low for exactly 3*1056 NCLK, VD falling edges exactly 554,400 NCLK (1,108,800 CLK) apart.
- DEN on a visible line (vcnt=35) -> rises 216 NCLK after HD falls and stays high for exactly 800 NCLK. Exactly 480 lines per frame carry DEN pulses; vcnt 0..34 and 515..524 have DEN=0.
- RGB content, sampled at NCLK rising edges -> pixel x=0 is FFFFFF, x=99 FFFFFF, x=100 FFFF00, x=250 00FFFF, x=450 FF00FF, x=650 0000FF, x=799 000000. Every DEN=0 sample is 000000.
- Reset asserted mid-frame for 5 CLK, then released -> outputs return to reset values at once; the first HD and VD falling edges occur at the first pixel step after release.

Source files
------------

// File: rtl/imagenes_lcd.sv
// imagenes_lcd: timing generator and colour-bar test image for an 800x480
// parallel-RGB TFT panel. The 50 MHz system clock is halved into the pixel
// clock NCLK. Every sync, enable and colour output comes from a register and
// changes only on NCLK falling edges, so the panel samples stable data on
// NCLK rising edges.
module imagenes_lcd #(
  parameter int H_ACTIVE = 800,
  parameter int H_SYNC   = 30,
  parameter int H_BLANK  = 216,
  parameter int H_TOTAL  = 1056,
  parameter int V_ACTIVE = 480,
  parameter int V_SYNC   = 3,
  parameter int V_BLANK  = 35,
  parameter int V_TOTAL  = 525,
  parameter int BAR_W    = 100
) (
  input  logic       CLK,
  input  logic       RST_n,   // active-high asynchronous reset despite the name
  output logic       NCLK,
  output logic       GREST,
  output logic       HD,
  output logic       VD,
  output logic       DEN,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  // Sized copies of the timing limits, so the counter compares need no casts.
  localparam logic [HW-1:0] H_LAST_C  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_C  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_BLANK_C = HW'(H_BLANK);
  localparam logic [HW-1:0] H_END_C   = HW'(H_BLANK + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST_C  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_BLANK_C = VW'(V_BLANK);
  localparam logic [VW-1:0] V_END_C   = VW'(V_BLANK + V_ACTIVE);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Bar number of a visible column: the number of bar boundaries at or left of x.
  function automatic logic [2:0] bar_of(input logic [HW-1:0] x);
    logic [2:0] bar;
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= HW'(i * BAR_W)) bar = 3'(i);
    end
    return bar;
  endfunction

  // Colour of each bar, left to right.
  function automatic rgb_t bar_colour(input logic [2:0] bar);
    rgb_t c;
    case (bar)
      3'd0:    c = '{r: 8'hFF, g: 8'hFF, b: 8'hFF}; // white
      3'd1:    c = '{r: 8'hFF, g: 8'hFF, b: 8'h00}; // yellow
      3'd2:    c = '{r: 8'h00, g: 8'hFF, b: 8'hFF}; // cyan
      3'd3:    c = '{r: 8'h00, g: 8'hFF, b: 8'h00}; // green
      3'd4:    c = '{r: 8'hFF, g: 8'h00, b: 8'hFF}; // magenta
      3'd5:    c = '{r: 8'hFF, g: 8'h00, b: 8'h00}; // red
      3'd6:    c = '{r: 8'h00, g: 8'h00, b: 8'hFF}; // blue
      default: c = '{r: 8'h00, g: 8'h00, b: 8'h00}; // black
    endcase
    return c;
  endfunction

  logic          nclk_q;
  logic          grest_q;
  logic          first_q, first_d;   // first pixel step after reset still pending
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          hd_q, hd_d;
  logic          vd_q, vd_d;
  logic          den_q, den_d;
  rgb_t          pix_q, pix_d;
  logic          step;
  logic [HW-1:0] col;

  // A pixel step happens on the CLK edge that takes NCLK from 1 to 0.
  assign step = nclk_q;
  assign col  = hcnt_d - H_BLANK_C;

  // Next counter values and the outputs decoded from them.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    first_d = first_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    if (step) begin
      if (first_q) begin
        // The first step after reset presents hcnt=0/vcnt=0 rather than
        // advancing, so the opening HD and VD pulses are full width.
        first_d = 1'b0;
        hcnt_d  = '0;
        vcnt_d  = '0;
      end else if (hcnt_q == H_LAST_C) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST_C) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
    hd_d  = (hcnt_d >= H_SYNC_C);
    vd_d  = (vcnt_d >= V_SYNC_C);
    den_d = (hcnt_d >= H_BLANK_C) && (hcnt_d < H_END_C) &&
            (vcnt_d >= V_BLANK_C) && (vcnt_d < V_END_C);
    pix_d = den_d ? bar_colour(bar_of(col)) : '0;
  end

  // Pixel clock divider and panel reset release.
  always_ff @(posedge CLK or posedge RST_n) begin
    if (RST_n) begin
      nclk_q  <= 1'b0;
      grest_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      nclk_q  <= ~nclk_q;
      grest_q <= 1'b1;
    end
  end

  // Counters and registered outputs advance together on each pixel step.
  always_ff @(posedge CLK or posedge RST_n) begin
    if (RST_n) begin
      first_q <= 1'b1;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hd_q    <= 1'b1;
      vd_q    <= 1'b1;
      den_q   <= 1'b0;
      pix_q   <= '0;
    end else begin
      first_q <= first_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      if (step) begin
        hd_q  <= hd_d;
        vd_q  <= vd_d;
        den_q <= den_d;
        pix_q <= pix_d;
      end
    end
  end

  assign NCLK  = nclk_q;
  assign GREST = grest_q;
  assign HD    = hd_q;
  assign VD    = vd_q;
  assign DEN   = den_q;
  assign R     = pix_q.r;
  assign G     = pix_q.g;
  assign B     = pix_q.b;

endmodule

// File: tb/tb_imagenes_lcd.sv
// tb_imagenes_lcd: directed bench for imagenes_lcd. Horizontal timing and the
// colour bars use the real panel values; the vertical frame is shortened
// (3 sync, 6 blank, 4 active, 12 total lines) so a whole frame fits in a
// short run. Expected values are hand-computed constants.
module tb_imagenes_lcd;

  localparam int HALF       = 10;    // CLK half period (50 MHz)
  localparam int V_SYNC_T   = 3;
  localparam int V_BLANK_T  = 6;
  localparam int V_ACTIVE_T = 4;
  localparam int V_TOTAL_T  = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       NCLK, GREST, HD, VD, DEN;
  logic [7:0] R, G, B;

  always #HALF clk = ~clk;

  imagenes_lcd #(
    .V_SYNC  (V_SYNC_T),
    .V_BLANK (V_BLANK_T),
    .V_ACTIVE(V_ACTIVE_T),
    .V_TOTAL (V_TOTAL_T)
  ) dut (
    .CLK  (clk),
    .RST_n(rst),
    .NCLK (NCLK),
    .GREST(GREST),
    .HD   (HD),
    .VD   (VD),
    .DEN  (DEN),
    .R    (R),
    .G    (G),
    .B    (B)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Measurements taken at NCLK rising edges, where the panel samples.
  bit          mon_en = 1'b0;
  int          s;
  logic        p_hd, p_vd, p_den;
  int          first_hd_fall, last_hd_fall, hd_low, hd_period, hd_falls;
  int          first_vd_fall, last_vd_fall, vd_low, vd_period, vd_falls;
  int          den_start, den_off, den_len;
  int          line_idx, den_lines_frame, frame_den_lines, first_den_line, last_den_line;
  int          blank_nz;
  logic [23:0] line_rgb [800];

  task automatic mon_reset();
    s = 0;
    p_hd = 1'b1; p_vd = 1'b1; p_den = 1'b0;
    first_hd_fall = -1; last_hd_fall = 0; hd_low = -1; hd_period = -1; hd_falls = 0;
    first_vd_fall = -1; last_vd_fall = 0; vd_low = -1; vd_period = -1; vd_falls = 0;
    den_start = 0; den_off = -1; den_len = -1;
    line_idx = 0; den_lines_frame = 0; frame_den_lines = -1;
    first_den_line = -1; last_den_line = -1;
    blank_nz = 0;
    for (int i = 0; i < 800; i++) line_rgb[i] = 24'hx;
  endtask

  always @(posedge NCLK) begin
    if (mon_en) begin
      #1;
      if (p_hd && !HD) begin
        if (hd_falls > 0) hd_period = s - last_hd_fall;
        else first_hd_fall = s;
        last_hd_fall = s;
        hd_falls++;
        line_idx++;
      end
      if (!p_hd && HD) hd_low = s - last_hd_fall;
      if (p_vd && !VD) begin
        if (vd_falls > 0) begin
          vd_period = s - last_vd_fall;
          frame_den_lines = den_lines_frame;
        end else begin
          first_vd_fall = s;
        end
        last_vd_fall = s;
        vd_falls++;
        line_idx = 0;
        den_lines_frame = 0;
      end
      if (!p_vd && VD) vd_low = s - last_vd_fall;
      if (!p_den && DEN) begin
        den_start = s;
        den_off   = s - last_hd_fall;
        if (den_lines_frame == 0) first_den_line = line_idx;
        last_den_line = line_idx;
        den_lines_frame++;
      end
      if (p_den && !DEN) den_len = s - den_start;
      if (DEN) begin
        if (s - den_start < 800) line_rgb[s - den_start] = {R, G, B};
      end else if ({R, G, B} != 24'h0) begin
        blank_nz++;
      end
      p_hd = HD; p_vd = VD; p_den = DEN;
      s++;
    end
  end

  // Column / expected colour pairs across every bar and its edges.
  int          px_x   [11] = '{0, 99, 100, 199, 200, 250, 350, 450, 550, 650, 799};
  logic [23:0] px_exp [11] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00,
                               24'h00FFFF, 24'h00FFFF, 24'h00FF00, 24'hFF00FF,
                               24'hFF0000, 24'h0000FF, 24'h000000};

  longint t0, t1;

  initial begin
    mon_reset();
    // Reset held for 20 CLK: every output at its reset value throughout.
    repeat (20) begin
      @(negedge clk);
      check("rst_ctl", 32'({GREST, NCLK, HD, VD, DEN}), 32'b00110);
      check("rst_rgb", 32'({R, G, B}), 32'h0);
    end

    @(negedge clk);
    mon_en = 1'b1;
    rst    = 1'b0;

    @(posedge NCLK); t0 = $time;
    @(posedge NCLK); t1 = $time;
    check("nclk_period", 32'(t1 - t0), 32'(4 * HALF));
    #1 check("grest_run", 32'(GREST), 32'h1);

    // One full shortened frame, bounded.
    for (int i = 0; i < 30000 && vd_falls < 2; i++) @(negedge clk);
    check("frame_done", 32'(vd_falls >= 2), 32'h1);

    check("hd_first_fall", 32'(first_hd_fall), 32'd1);
    check("vd_first_fall", 32'(first_vd_fall), 32'd1);
    check("hd_low",        32'(hd_low),        32'd30);
    check("hd_period",     32'(hd_period),     32'd1056);
    check("vd_low",        32'(vd_low),        32'(3 * 1056));
    check("vd_period",     32'(vd_period),     32'(V_TOTAL_T * 1056));
    check("den_offset",    32'(den_off),       32'd216);
    check("den_len",       32'(den_len),       32'd800);
    check("den_lines",     32'(frame_den_lines), 32'(V_ACTIVE_T));
    check("den_first_ln",  32'(first_den_line),  32'(V_BLANK_T));
    check("den_last_ln",   32'(last_den_line),   32'(V_BLANK_T + V_ACTIVE_T - 1));
    check("blank_rgb_nz",  32'(blank_nz),        32'd0);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("rgb_x%0d", px_x[i]), 32'(line_rgb[px_x[i]]), 32'(px_exp[i]));
    end

    // Mid-frame reset: VD is low here (line 1 of the frame).
    repeat (3000) @(negedge clk);
    check("pre_rst_vd", 32'(VD), 32'h0);
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check("mid_rst_ctl", 32'({GREST, NCLK, HD, VD, DEN}), 32'b00110);
    check("mid_rst_rgb", 32'({R, G, B}), 32'h0);
    repeat (4) @(negedge clk);
    check("mid_rst_hold", 32'({GREST, NCLK, HD, VD, DEN}), 32'b00110);

    // Release: the first edge raises NCLK, the second is the first pixel step.
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_edge1", 32'({GREST, NCLK, HD, VD, DEN}), 32'b11110);
    @(posedge clk); #1;
    check("rel_edge2", 32'({GREST, NCLK, HD, VD, DEN}), 32'b10000);
    check("rel_rgb",   32'({R, G, B}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
